// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scanner.
package seg_pkg;

    // All segments dark (active-low pattern, ABCDEFG with A in the MSB).
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs, active-low, ABCDEFG order (MSB = A).
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Index of the highest nonzero nibble; 0 when every nibble is zero.
    // Takes the widest legal value (16 digits); callers zero-extend.
    function automatic logic [3:0] highest_nz(input logic [63:0] v);
        logic [3:0] hi;
        hi = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i*4 +: 4] != 4'h0) hi = 4'(i);
        end
        return hi;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup into the shared glyph array.
    always_comb begin
        seg = GLYPH[nibble];
    end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed common-anode 7-segment driver with tear-free shadow
// update at frame boundaries, per-slot blanking and leading-zero suppression.
module seg_scan
    import seg_pkg::*;
#(
    parameter int NDIG     = 8,
    parameter int PRESCALE = 100000,
    parameter int BLANK    = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*NDIG-1:0]   value,
    input  logic [NDIG-1:0]     dp_in,
    input  logic [NDIG-1:0]     en_in,
    input  logic                lzs,
    output logic [6:0]          segment,
    output logic                dp,
    output logic [NDIG-1:0]     digit,
    output logic                frame_done,
    output logic                pending
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NDIG);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] pend_val_q, pend_val_d, sh_val_q, sh_val_d;
    logic [NDIG-1:0]   pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
    logic [NDIG-1:0]   pend_en_q, pend_en_d, sh_en_q, sh_en_d;
    logic              pend_lzs_q, pend_lzs_d, sh_lzs_q, sh_lzs_d;
    logic              pending_q, pending_d;
    logic [6:0]        segment_q, segment_d;
    logic              dp_q, dp_d;
    logic [NDIG-1:0]   digit_q, digit_d;
    logic              frame_done_q, frame_done_d;

    logic              tick, wrap, blank, dark, cur_dp, cur_en;
    logic [3:0]        nibble, hi;
    logic [6:0]        glyph;

    seg_decode u_decode (
        .nibble (nibble),
        .seg    (glyph)
    );

    // Next-state logic. Outputs are decoded from the next-state values so
    // that the registered outputs line up with the slot that cnt/idx enter.
    always_comb begin
        tick = (cnt_q == CW'(PRESCALE - 1));
        wrap = tick && (idx_q == IW'(NDIG - 1));

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

        // Last load wins; the captured copy is only consumed at a wrap.
        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        pend_en_d  = load ? en_in : pend_en_q;
        pend_lzs_d = load ? lzs   : pend_lzs_q;

        pending_d = pending_q;
        if (wrap)      pending_d = 1'b0;
        else if (load) pending_d = 1'b1;

        // A load on the wrap cycle bypasses the pending copy entirely.
        sh_val_d = sh_val_q;
        sh_dp_d  = sh_dp_q;
        sh_en_d  = sh_en_q;
        sh_lzs_d = sh_lzs_q;
        if (wrap) begin
            sh_val_d = load ? value : pend_val_q;
            sh_dp_d  = load ? dp_in : pend_dp_q;
            sh_en_d  = load ? en_in : pend_en_q;
            sh_lzs_d = load ? lzs   : pend_lzs_q;
        end

        nibble = 4'h0;
        cur_dp = 1'b0;
        cur_en = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_d == IW'(i)) begin
                nibble = sh_val_d[4*i +: 4];
                cur_dp = sh_dp_d[i];
                cur_en = sh_en_d[i];
            end
        end

        hi    = highest_nz(64'(sh_val_d));
        dark  = !cur_en ||
                (sh_lzs_d && (idx_d != '0) && (32'(idx_d) > 32'(hi)));
        blank = (cnt_d < CW'(BLANK));

        segment_d    = dark ? SEG_OFF : glyph;
        dp_d         = dark ? 1'b1 : !cur_dp;
        digit_d      = '1;
        if (!dark && !blank) digit_d = ~(NDIG'(1) << idx_d);
        frame_done_d = wrap;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '1;
            pend_lzs_q   <= 1'b0;
            pending_q    <= 1'b0;
            sh_val_q     <= '0;
            sh_dp_q      <= '0;
            sh_en_q      <= '1;
            sh_lzs_q     <= 1'b0;
            segment_q    <= SEG_OFF;
            dp_q         <= 1'b1;
            digit_q      <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_lzs_q   <= pend_lzs_d;
            pending_q    <= pending_d;
            sh_val_q     <= sh_val_d;
            sh_dp_q      <= sh_dp_d;
            sh_en_q      <= sh_en_d;
            sh_lzs_q     <= sh_lzs_d;
            segment_q    <= segment_d;
            dp_q         <= dp_d;
            digit_q      <= digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segment    = segment_q;
    assign dp         = dp_q;
    assign digit      = digit_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with NDIG=4, PRESCALE=8, BLANK=2.
// Frame position pos = cyc % 32 = slot*8 + cnt, cyc counted from reset release.
module tb_seg_scan;

    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G7 = 7'b0001111;
    localparam logic [6:0] GA = 7'b0001000, GB = 7'b1100000, GE = 7'b0110000;
    localparam logic [6:0] GF = 7'b0111000, OFF = 7'h7F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  en_in = 4'hF;
    logic        lzs = 1'b0;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  digit;
    logic        frame_done;
    logic        pending;

    int tests = 0;
    int failed = 0;
    int cyc = 0;

    seg_scan #(.NDIG(4), .PRESCALE(8), .BLANK(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .lzs        (lzs),
        .segment    (segment),
        .dp         (dp),
        .digit      (digit),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance to frame position p (no step if already there), bounded.
    task automatic goto(input int p);
        int n;
        n = 0;
        while ((cyc % 32) != p && n < 40) begin
            step();
            n++;
        end
        tests++;
        if ((cyc % 32) != p) begin
            failed++;
            $display("FAIL goto: reached pos %0d, wanted %0d", cyc % 32, p);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d,
                           input logic [3:0] e, input logic z);
        value = v; dp_in = d; en_in = e; lzs = z; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        int lit;
        rst_n = 1'b0;
        repeat (3) step();
        tests++; if (segment !== OFF)   begin failed++; $display("FAIL rst_seg: got %h want %h", segment, OFF); end
        tests++; if (digit !== 4'hF)    begin failed++; $display("FAIL rst_digit: got %b want 1111", digit); end
        tests++; if (dp !== 1'b1)       begin failed++; $display("FAIL rst_dp: got %b want 1", dp); end
        tests++; if (pending !== 1'b0)  begin failed++; $display("FAIL rst_pending: got %b want 0", pending); end
        tests++; if (frame_done !== 1'b0) begin failed++; $display("FAIL rst_fd: got %b want 0", frame_done); end
        rst_n = 1'b1;
        cyc = 0;
        tests++; if (segment !== OFF)   begin failed++; $display("FAIL post_rst_seg: got %h want %h", segment, OFF); end
        tests++; if (digit !== 4'hF)    begin failed++; $display("FAIL post_rst_digit: got %b want 1111", digit); end
        step();
        tests++; if (segment !== G0)    begin failed++; $display("FAIL slot0_blank_seg: got %b want %b", segment, G0); end
        tests++; if (digit !== 4'hF)    begin failed++; $display("FAIL slot0_blank_digit: got %b want 1111", digit); end
        lit = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (digit === 4'b1110) lit++;
        end
        tests++; if (lit != 6)          begin failed++; $display("FAIL slot0_lit_len: got %0d want 6", lit); end
        tests++; if (digit !== 4'hF)    begin failed++; $display("FAIL slot1_blank: got %b want 1111", digit); end
        goto(10);
        tests++; if (digit !== 4'b1101) begin failed++; $display("FAIL slot1_digit: got %b want 1101", digit); end
    endtask

    task automatic test_full_scan();
        int fd;
        do_load(16'h1A0F, 4'h0, 4'hF, 1'b0);
        tests++; if (pending !== 1'b1)  begin failed++; $display("FAIL scan_pending: got %b want 1", pending); end
        goto(31);
        step();
        tests++; if (frame_done !== 1'b1) begin failed++; $display("FAIL scan_fd: got %b want 1", frame_done); end
        tests++; if (pending !== 1'b0)  begin failed++; $display("FAIL scan_pend_clr: got %b want 0", pending); end
        step();
        tests++; if (frame_done !== 1'b0) begin failed++; $display("FAIL scan_fd_width: got %b want 0", frame_done); end
        goto(4);
        tests++; if (segment !== GF || digit !== 4'b1110) begin failed++; $display("FAIL scan_s0: got %b/%b want %b/1110", segment, digit, GF); end
        goto(12);
        tests++; if (segment !== G0 || digit !== 4'b1101) begin failed++; $display("FAIL scan_s1: got %b/%b want %b/1101", segment, digit, G0); end
        goto(20);
        tests++; if (segment !== GA || digit !== 4'b1011) begin failed++; $display("FAIL scan_s2: got %b/%b want %b/1011", segment, digit, GA); end
        goto(28);
        tests++; if (segment !== G1 || digit !== 4'b0111) begin failed++; $display("FAIL scan_s3: got %b/%b want %b/0111", segment, digit, G1); end
        fd = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (frame_done === 1'b1) begin
                fd++;
                tests++; if ((cyc % 32) != 0) begin failed++; $display("FAIL scan_fd_pos: got pos %0d want 0", cyc % 32); end
            end
        end
        tests++; if (fd != 2)           begin failed++; $display("FAIL scan_fd_count: got %0d want 2", fd); end
    endtask

    task automatic test_tear_free();
        goto(11);
        do_load(16'h1234, 4'h0, 4'hF, 1'b0);
        tests++; if (pending !== 1'b1 || segment !== G0) begin failed++; $display("FAIL tear_s1: got p%b %b want p1 %b", pending, segment, G0); end
        goto(20);
        tests++; if (pending !== 1'b1 || segment !== GA) begin failed++; $display("FAIL tear_s2: got p%b %b want p1 %b", pending, segment, GA); end
        goto(31);
        tests++; if (pending !== 1'b1)  begin failed++; $display("FAIL tear_pend31: got %b want 1", pending); end
        step();
        tests++; if (pending !== 1'b0 || segment !== G4) begin failed++; $display("FAIL tear_new_s0: got p%b %b want p0 %b", pending, segment, G4); end
        goto(12);
        tests++; if (segment !== G3)    begin failed++; $display("FAIL tear_new_s1: got %b want %b", segment, G3); end
        goto(20);
        tests++; if (segment !== G2)    begin failed++; $display("FAIL tear_new_s2: got %b want %b", segment, G2); end
        goto(28);
        tests++; if (segment !== G1)    begin failed++; $display("FAIL tear_new_s3: got %b want %b", segment, G1); end
    endtask

    task automatic test_back_to_back();
        goto(5);
        do_load(16'h1111, 4'h0, 4'hF, 1'b0);
        do_load(16'h2222, 4'h0, 4'hF, 1'b0);
        goto(31);
        step();
        goto(4);
        tests++; if (segment !== G2)    begin failed++; $display("FAIL b2b_s0: got %b want %b", segment, G2); end
        goto(12);
        tests++; if (segment !== G2)    begin failed++; $display("FAIL b2b_s1: got %b want %b", segment, G2); end
    endtask

    task automatic test_coincident();
        goto(31);
        do_load(16'hBEEF, 4'h0, 4'hF, 1'b0);
        tests++; if (segment !== GF || pending !== 1'b0 || frame_done !== 1'b1) begin failed++; $display("FAIL coin_s0: got %b p%b fd%b want %b p0 fd1", segment, pending, frame_done, GF); end
        goto(12);
        tests++; if (segment !== GE || pending !== 1'b0) begin failed++; $display("FAIL coin_s1: got %b p%b want %b p0", segment, pending, GE); end
        goto(20);
        tests++; if (segment !== GE || pending !== 1'b0) begin failed++; $display("FAIL coin_s2: got %b p%b want %b p0", segment, pending, GE); end
        goto(28);
        tests++; if (segment !== GB || pending !== 1'b0) begin failed++; $display("FAIL coin_s3: got %b p%b want %b p0", segment, pending, GB); end
    endtask

    task automatic test_suppress();
        goto(31);
        do_load(16'h0070, 4'h0, 4'hF, 1'b1);
        goto(4);
        tests++; if (segment !== G0 || digit !== 4'b1110) begin failed++; $display("FAIL lzs70_s0: got %b/%b want %b/1110", segment, digit, G0); end
        goto(12);
        tests++; if (segment !== G7 || digit !== 4'b1101) begin failed++; $display("FAIL lzs70_s1: got %b/%b want %b/1101", segment, digit, G7); end
        goto(20);
        tests++; if (segment !== OFF || digit !== 4'hF || dp !== 1'b1) begin failed++; $display("FAIL lzs70_s2: got %b/%b/%b want 1111111/1111/1", segment, digit, dp); end
        goto(28);
        tests++; if (segment !== OFF || digit !== 4'hF) begin failed++; $display("FAIL lzs70_s3: got %b/%b want 1111111/1111", segment, digit); end
        goto(31);
        do_load(16'h0000, 4'h0, 4'hF, 1'b1);
        goto(4);
        tests++; if (segment !== G0 || digit !== 4'b1110) begin failed++; $display("FAIL lzs0_s0: got %b/%b want %b/1110", segment, digit, G0); end
        goto(12);
        tests++; if (segment !== OFF || digit !== 4'hF) begin failed++; $display("FAIL lzs0_s1: got %b/%b want 1111111/1111", segment, digit); end
        goto(31);
        do_load(16'h1A0F, 4'b0001, 4'b1011, 1'b0);
        step();
        tests++; if (segment !== GF || digit !== 4'hF || dp !== 1'b0) begin failed++; $display("FAIL mask_blank: got %b/%b/%b want %b/1111/0", segment, digit, dp, GF); end
        goto(4);
        tests++; if (segment !== GF || digit !== 4'b1110 || dp !== 1'b0) begin failed++; $display("FAIL mask_s0: got %b/%b/%b want %b/1110/0", segment, digit, dp, GF); end
        goto(12);
        tests++; if (segment !== G0 || digit !== 4'b1101 || dp !== 1'b1) begin failed++; $display("FAIL mask_s1: got %b/%b/%b want %b/1101/1", segment, digit, dp, G0); end
        goto(20);
        tests++; if (segment !== OFF || digit !== 4'hF || dp !== 1'b1) begin failed++; $display("FAIL mask_s2: got %b/%b/%b want 1111111/1111/1", segment, digit, dp); end
        goto(28);
        tests++; if (segment !== G1 || digit !== 4'b0111 || dp !== 1'b1) begin failed++; $display("FAIL mask_s3: got %b/%b/%b want %b/0111/1", segment, digit, dp, G1); end
    endtask

    task automatic test_mid_reset();
        goto(17);
        do_load(16'h5555, 4'hF, 4'hF, 1'b0);
        tests++; if (pending !== 1'b1)  begin failed++; $display("FAIL mrst_pend_set: got %b want 1", pending); end
        rst_n = 1'b0;
        step();
        tests++; if (segment !== OFF || digit !== 4'hF || dp !== 1'b1) begin failed++; $display("FAIL mrst_out: got %b/%b/%b want 1111111/1111/1", segment, digit, dp); end
        tests++; if (pending !== 1'b0 || frame_done !== 1'b0) begin failed++; $display("FAIL mrst_flags: got p%b fd%b want p0 fd0", pending, frame_done); end
        rst_n = 1'b1;
        cyc = 0;
        goto(4);
        tests++; if (segment !== G0 || digit !== 4'b1110 || dp !== 1'b1) begin failed++; $display("FAIL mrst_s0: got %b/%b/%b want %b/1110/1", segment, digit, dp, G0); end
        goto(31);
        step();
        tests++; if (frame_done !== 1'b1 || pending !== 1'b0) begin failed++; $display("FAIL mrst_wrap: got fd%b p%b want fd1 p0", frame_done, pending); end
        goto(12);
        tests++; if (segment !== G0)    begin failed++; $display("FAIL mrst_discard: got %b want %b", segment, G0); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_tear_free();
        test_back_to_back();
        test_coincident();
        test_suppress();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
